ahb_sensor_in: RTL and testbench
================================

Name: ahb_sensor_in

Overview:
- AHB-Lite slave for the cycle computer's inputs, complementing the display output slave.
- Synchronises and debounces two push buttons (nMode, nTrip) and two reed sensors (Fork = wheel, Crank = pedal).
- Latches press and revolution events for software, measures wheel and crank periods in ticks, and counts wheel revolutions.
- Single-cycle, zero-wait-state slave on the M0 AHB-Lite bus.

Parameters:
- TICK_DIV, 33: HCLK cycles per tick (about 1 ms at 32.768 kHz); range 2..65535.
- DEBOUNCE_TICKS, 20: consecutive ticks an input must hold a new level before the debounced level changes; range 1..255.
- PERIOD_W, 16: width of the period counters and registers; range 8..32.

Ports:
- HCLK  input  1  bus clock; only clock in the block.
- HRESET  input  1  asynchronous, active-high reset.
- HADDR  input  32  only HADDR[4:2] decoded.
- HWDATA  input  32  write data (data phase).
- HSIZE  input  3  ignored; word transfers only.
- HTRANS  input  2  transfer type.
- HWRITE  input  1  1 = write.
- HREADY  input  1  bus ready.
- HSEL  input  1  slave select.
- HRDATA  output  32  read data.
- HREADYOUT  output  1  tied 1.
- nMode  input  1  Mode button, active-low, asynchronous.
- nTrip  input  1  Trip button, active-low, asynchronous.
- Fork  input  1  wheel reed switch, active-high, asynchronous.
- Crank  input  1  crank reed switch, active-high, asynchronous.

Behaviour:
- Reset (HRESET=1, async): all registers, counters, synchronisers and debounced levels are 0. Button debounced levels reset to 1 (released). HRDATA=0.
- Address phase registered only when HREADY & HSEL & HTRANS!=0; captures write_enable, read_enable and addr=HADDR[4:2]. Otherwise all three clear.
- Writes take HWDATA in the cycle after the address phase.
- HRDATA is combinational from the registered addr when read_enable=1, otherwise 0.
- Tick prescaler: counts 0..TICK_DIV-1 and wraps; tick is a one-cycle pulse at wrap.
- Input path: each input passes through a 2-flop synchroniser, then a debouncer.
  - Debounce counter clears whenever the synchronised level equals the debounced level.
  - On each tick with a mismatch, the counter increments.
  - When the counter reaches DEBOUNCE_TICKS, the debounced level takes the synchronised level and the counter clears.
- Events are one-cycle pulses:
  - ModeEv / TripEv: debounced 1->0.
  - WheelEv / CrankEv: debounced 0->1.
- Period logic, per sensor:
  - Running counter increments on each tick and saturates at all-ones.
  - On the sensor's event: period register <= counter; counter <= 0.
  - When the counter reaches all-ones, the period register is also forced to all-ones (stopped indication). It stays there until the next event.
- Register map (offset: read / write):
  - 0x00 Status:
    - Read: [0] ModeP, [1] TripP, [2] WheelP, [3] CrankP, [4] debounced nMode, [5] debounced nTrip, [6] debounced Fork, [7] debounced Crank, other bits 0.
    - Write: W1C on bits [3:0].
  - 0x04 WheelPeriod: read only, zero-extended.
  - 0x08 CrankPeriod: read only, zero-extended.
  - 0x0C WheelCount: read 32-bit revolution count; any write clears it.
  - 0x10-0x1C: read 0, writes ignored (see Optional Feature for 0x10).
- Sticky bits: ModeP, TripP, WheelP and CrankP set on their event. If an event and a W1C hit the same bit in the same cycle, set wins.
- WheelCount: +1 per WheelEv, wraps 0xFFFFFFFF->0. A write-clear coincident with WheelEv leaves 1.
- Reads have no side effects.
- Reset asserted mid-debounce or mid-period returns everything to reset values. No event is generated on reset release.
- Latency: input edge -> sticky bit set in 2 (sync) + DEBOUNCE_TICKS ticks + 1 cycle. This is jittered by up to one tick.

Optional Feature:
- Macro SENSOR_IRQ_EN.
- When defined:
  - Adds output port IRQ (1 bit), registered, reset 0.
  - Adds a mask register at 0x10, read/write bits [3:0], reset 0.
  - IRQ = |(sticky[3:0] & mask), updated the cycle after any change.
- When undefined:
  - No IRQ port.
  - 0x10 reads 0 and writes are ignored.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08, 0x0C -> 0x30, 0, 0, 0. Release reset with nMode=0: no ModeP.
- TICK_DIV=4, DEBOUNCE_TICKS=3. Drive nMode low for 2 ticks then high -> ModeP stays 0. Drive low for 20 cycles -> Status bit0=1 within 2+12+4 cycles. Write 0x1 to 0x00 -> reads 0x20.
- Fork pulses every 100 ticks (each held high 10 ticks), 3 pulses -> WheelPeriod=100, WheelCount=3, WheelP=1.
- PERIOD_W=8, no Crank pulse after one event -> CrankPeriod reads 0xFF after 255 ticks. Next pulse 300 ticks later -> still 0xFF. Next pulse 50 ticks after that -> 50.
- WheelEv in the same cycle as a W1C of bit2 and a write to 0x0C -> WheelP=1, WheelCount=1.
- With SENSOR_IRQ_EN: write mask 0x2, press Trip -> IRQ=1. Write 0x2 to 0x00 -> IRQ=0 one cycle later. Press Mode -> IRQ stays 0.

Source files
------------

// File: rtl/ahb_sensor_in.sv
// ---------------------------------------------------------------------------
// ahb_sensor_in
//
// AHB-Lite input slave for the cycle computer. Conditions the two push
// buttons (nMode, nTrip) and the two reed sensors (Fork = wheel,
// Crank = pedal): each input is synchronised, then debounced against a
// slow tick. The block latches press / revolution events for software,
// measures the wheel and crank periods in ticks, and counts wheel
// revolutions. Zero-wait-state slave (HREADYOUT tied high).
//
// Register map (HADDR[4:2]):
//   0x00 Status      R: [3:0] sticky ModeP/TripP/WheelP/CrankP,
//                       [7:4] debounced nMode/nTrip/Fork/Crank
//                    W: write-one-to-clear on [3:0]
//   0x04 WheelPeriod R: ticks between wheel events (zero-extended)
//   0x08 CrankPeriod R: ticks between crank events (zero-extended)
//   0x0C WheelCount  R: revolution count, W: any write clears
//   0x10 IrqMask     R/W [3:0] when SENSOR_IRQ_EN is defined, else reads 0
//   0x14-0x1C        read 0, writes ignored
//
// Optional feature macro: SENSOR_IRQ_EN (adds IRQ output and mask register).
//
// Ports:
//   HCLK       in   bus clock, the only clock
//   HRESET     in   asynchronous active-high reset
//   HADDR      in   [31:0] address, only [4:2] decoded
//   HWDATA     in   [31:0] write data (data phase)
//   HSIZE      in   [2:0] ignored, word transfers only
//   HTRANS     in   [1:0] transfer type
//   HWRITE     in   1 = write
//   HREADY     in   bus ready
//   HSEL       in   slave select
//   HRDATA     out  [31:0] read data
//   HREADYOUT  out  always 1
//   nMode      in   Mode button, active-low, asynchronous
//   nTrip      in   Trip button, active-low, asynchronous
//   Fork       in   wheel reed switch, active-high, asynchronous
//   Crank      in   crank reed switch, active-high, asynchronous
//   IRQ        out  (SENSOR_IRQ_EN only) registered OR of masked sticky bits
// ---------------------------------------------------------------------------
module ahb_sensor_in #(
    parameter int unsigned TICK_DIV       = 33,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned PERIOD_W       = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        nMode,
    input  logic        nTrip,
    input  logic        Fork,
    input  logic        Crank
`ifdef SENSOR_IRQ_EN
    ,
    output logic        IRQ
`endif
);

    localparam logic [15:0]         TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]          DEB_LAST  = 8'(DEBOUNCE_TICKS - 1);
    localparam logic [PERIOD_W-1:0] PER_MAX   = '1;

    // Input bit order used throughout: 0 = nMode, 1 = nTrip, 2 = Fork, 3 = Crank.
    // Buttons idle high, reeds idle low.
    localparam logic [3:0] LVL_IDLE = 4'b0011;

    // Saturating add for the period counters: once at all-ones, stay there.
    function automatic logic [PERIOD_W-1:0] sat_add(input logic [PERIOD_W-1:0] v,
                                                    input logic inc);
        return (v == PER_MAX) ? PER_MAX : v + PERIOD_W'(inc);
    endfunction

    assign HREADYOUT = 1'b1;

    logic unused_ok;
`ifdef SENSOR_IRQ_EN
    assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:4]};
`else
    assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:4]};
`endif

    // ---- bus address phase -> data phase ----
    logic       we_p0;
    logic       re_p0;
    logic [2:0] addr_p0;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            we_p0   <= 1'b0;
            re_p0   <= 1'b0;
            addr_p0 <= 3'd0;
        end else if (HREADY && HSEL && (HTRANS != 2'b00)) begin
            we_p0   <= HWRITE;
            re_p0   <= ~HWRITE;
            addr_p0 <= HADDR[4:2];
        end else begin
            we_p0   <= 1'b0;
            re_p0   <= 1'b0;
            addr_p0 <= 3'd0;
        end
    end

    logic wr_status;
    logic wr_wcount;
    assign wr_status = we_p0 && (addr_p0 == 3'd0);
    assign wr_wcount = we_p0 && (addr_p0 == 3'd3);

    // ---- tick prescaler ----
    logic [15:0] tick_cnt;
    logic        tick;
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tick_cnt <= 16'd0;
        end else if (tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // ---- two-flop synchroniser ----
    logic [3:0] raw;
    logic [3:0] sync_p0;
    logic [3:0] sync_p1;
    assign raw = {Crank, Fork, nTrip, nMode};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync_p0 <= 4'b0000;
            sync_p1 <= 4'b0000;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debouncer ----
    // The counter only runs while the synchronised level disagrees with the
    // debounced level; any agreement restarts the count, so a bounce shorter
    // than DEBOUNCE_TICKS ticks never reaches the debounced output.
    logic [3:0] deb;
    logic [3:0] deb_d;
    logic [7:0] db_cnt [4];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            deb   <= LVL_IDLE;
            deb_d <= LVL_IDLE;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (tick) begin
                    if (db_cnt[i] == DEB_LAST) begin
                        deb[i]    <= sync_p1[i];
                        db_cnt[i] <= 8'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // ---- event detection ----
    // Buttons fire on press (1->0), reeds on closure (0->1). deb and deb_d
    // reset to the same value, so leaving reset can never look like an edge.
    logic [3:0] ev;
    assign ev[0] = deb_d[0] & ~deb[0];
    assign ev[1] = deb_d[1] & ~deb[1];
    assign ev[2] = ~deb_d[2] & deb[2];
    assign ev[3] = ~deb_d[3] & deb[3];

    // ---- period measurement (index 0 = wheel, 1 = crank) ----
    // On an event the captured period includes a tick landing in that same
    // cycle, while the counter restarts from zero; this way the period equals
    // the number of ticks between consecutive events regardless of phase.
    logic [PERIOD_W-1:0] per_cnt [2];
    logic [PERIOD_W-1:0] per_reg [2];
    logic [1:0]          per_ev;
    assign per_ev = ev[3:2];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int j = 0; j < 2; j++) begin
                per_cnt[j] <= '0;
                per_reg[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (per_ev[j]) begin
                    per_reg[j] <= sat_add(per_cnt[j], tick);
                    per_cnt[j] <= '0;
                end else begin
                    if (tick) begin
                        per_cnt[j] <= sat_add(per_cnt[j], 1'b1);
                    end
                    // Saturated counter means the sensor has stopped.
                    if (per_cnt[j] == PER_MAX) begin
                        per_reg[j] <= PER_MAX;
                    end
                end
            end
        end
    end

    // ---- sticky event bits and wheel revolution count ----
    logic [3:0]  sticky;
    logic [31:0] wheel_count;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sticky      <= 4'b0000;
            wheel_count <= 32'd0;
        end else begin
            // A new event wins over a coincident write-one-to-clear.
            sticky <= (sticky & ~(wr_status ? HWDATA[3:0] : 4'b0000)) | ev;
            if (wr_wcount) begin
                wheel_count <= {31'd0, ev[2]};
            end else if (ev[2]) begin
                wheel_count <= wheel_count + 32'd1;
            end
        end
    end

`ifdef SENSOR_IRQ_EN
    // ---- interrupt mask and registered IRQ ----
    logic [3:0] irq_mask;
    logic       irq_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_mask <= 4'b0000;
            irq_q    <= 1'b0;
        end else begin
            if (we_p0 && (addr_p0 == 3'd4)) begin
                irq_mask <= HWDATA[3:0];
            end
            irq_q <= |(sticky & irq_mask);
        end
    end

    assign IRQ = irq_q;
`endif

    // ---- read mux ----
    always_comb begin
        HRDATA = 32'd0;
        if (re_p0) begin
            case (addr_p0)
                3'd0: HRDATA[7:0] = {deb, sticky};
                3'd1: HRDATA[PERIOD_W-1:0] = per_reg[0];
                3'd2: HRDATA[PERIOD_W-1:0] = per_reg[1];
                3'd3: HRDATA = wheel_count;
`ifdef SENSOR_IRQ_EN
                3'd4: HRDATA[3:0] = irq_mask;
`endif
                default: HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sensor_in.sv
// ---------------------------------------------------------------------------
// tb_ahb_sensor_in
//
// Randomised self-checking bench for ahb_sensor_in (TICK_DIV=4,
// DEBOUNCE_TICKS=3, PERIOD_W=8). A behavioural model keeps the expected
// sticky bits, debounced idle levels and wheel count in terms of clean
// presses/glitches applied; periods are predicted from pulse spacing in ticks.
// ---------------------------------------------------------------------------
module tb_ahb_sensor_in;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int PW = 8;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        nMode;
    logic        nTrip;
    logic        Fork;
    logic        Crank;
`ifdef SENSOR_IRQ_EN
    logic        IRQ;
`endif

    ahb_sensor_in #(
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DB),
        .PERIOD_W      (PW)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HSIZE    (HSIZE),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HREADY   (HREADY),
        .HSEL     (HSEL),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .nMode    (nMode),
        .nTrip    (nTrip),
        .Fork     (Fork),
        .Crank    (Crank)
`ifdef SENSOR_IRQ_EN
        ,
        .IRQ      (IRQ)
`endif
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [3:0]  exp_sticky;
    logic [3:0]  exp_lvl;
    logic [31:0] exp_wcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {24'd0, exp_lvl, exp_sticky};
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic bus_addr(input logic [31:0] a, input logic wr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = a;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_addr(a, 1'b1);
        step();
        HWDATA = d;
        bus_idle();
        step();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_addr(a, 1'b0);
        step();
        d = HRDATA;
        bus_idle();
    endtask

    task automatic set_in(input int idx, input logic v);
        case (idx)
            0: nMode = v;
            1: nTrip = v;
            2: Fork  = v;
            default: Crank = v;
        endcase
    endtask

    function automatic logic act_lvl(input int idx);
        return (idx >= 2);
    endfunction

    task automatic inputs_idle();
        nMode = 1'b1;
        nTrip = 1'b1;
        Fork  = 1'b0;
        Crank = 1'b0;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        bus_idle();
        inputs_idle();
        hold(3);
        HRESET = 1'b0;
        exp_sticky = 4'b0000;
        exp_lvl    = 4'b0011;
        exp_wcnt   = 32'd0;
    endtask

    // A clean activation held long enough to pass the debouncer.
    task automatic press(input int idx, input int hold_c);
        set_in(idx, act_lvl(idx));
        hold(hold_c);
        set_in(idx, !act_lvl(idx));
        hold(24);
        exp_sticky[idx] = 1'b1;
        if (idx == 2) exp_wcnt = exp_wcnt + 32'd1;
    endtask

    // A bounce of at most (DB-1)*TD cycles: spans at most DB-1 ticks.
    task automatic glitch(input int idx, input int len);
        set_in(idx, act_lvl(idx));
        hold(len);
        set_in(idx, !act_lvl(idx));
        hold(24);
    endtask

    // From a fresh reset, raise Fork at a fixed cycle and put one bus access
    // with its data phase k cycles later. kind 0 = read WheelCount in that
    // data phase; 1 = clear WheelCount; 2 = W1C WheelP. Afterwards r1 holds
    // WheelCount and r2 the Status register (kind 0: r1 is the in-flight read).
    task automatic coin_trial(input int kind, input int k,
                              output logic [31:0] r1, output logic [31:0] r2);
        int f;
        do_reset();
        f = cyc + 1;
        wait_until(f);
        Fork = 1'b1;
        wait_until(f + k - 1);
        bus_addr((kind == 0) ? 32'h0C : ((kind == 1) ? 32'h0C : 32'h00), (kind != 0));
        step();
        r1 = HRDATA;
        HWDATA = (kind == 2) ? 32'h4 : 32'h0;
        bus_idle();
        step();
        r2 = 32'd0;
        if (kind != 0) begin
            hold(30);
            bus_read(32'h0C, r1);
            bus_read(32'h00, r2);
        end
        Fork = 1'b0;
    endtask

    logic [31:0] d;
    logic [31:0] r1;
    logic [31:0] r2;
    int          lat;
    int          idx;
    int          s1;
    int          t;
    int          kfirst;
    int          kc;
    logic [3:0]  m;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1;
        HADDR  = 32'd0;
        HWDATA = 32'd0;
        HSIZE  = 3'b010;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HSEL   = 1'b0;
        inputs_idle();
        exp_sticky = 4'b0000;
        exp_lvl    = 4'b0011;
        exp_wcnt   = 32'd0;
        hold(3);

        // ---- reset state ----
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
`ifdef SENSOR_IRQ_EN
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
`endif
        HRESET = 1'b0;
        bus_read(32'h00, d); chk("rst_status", d, 32'h30);
        bus_read(32'h04, d); chk("rst_wperiod", d, 32'd0);
        bus_read(32'h08, d); chk("rst_cperiod", d, 32'd0);
        bus_read(32'h0C, d); chk("rst_wcount", d, 32'd0);
`ifndef SENSOR_IRQ_EN
        bus_write(32'h10, 32'hF);
        bus_read(32'h10, d); chk("rd_0x10", d, 32'd0);
`endif
        bus_read(32'h14, d); chk("rd_0x14", d, 32'd0);
        bus_write(32'h1C, 32'hFFFF_FFFF);
        bus_read(32'h1C, d); chk("rd_0x1c", d, 32'd0);
        bus_write(32'h04, 32'hFFFF_FFFF);
        bus_read(32'h04, d); chk("ro_wperiod", d, 32'd0);

        // ---- release reset with Mode held: no event ----
        HRESET = 1'b1;
        hold(2);
        nMode = 1'b0;
        hold(1);
        HRESET = 1'b0;
        bus_read(32'h00, d); chk("rel_nmode_status", d, 32'h30);
        nMode = 1'b1;
        hold(24);
        bus_read(32'h00, d); chk("rel_nmode_later", d, exp_status());

        // ---- bounces never reach the sticky bits ----
        for (int i = 0; i < 6; i++) begin
            idx = int'($urandom_range(0, 3));
            glitch(idx, int'($urandom_range(1, (DB - 1) * TD)));
            bus_read(32'h00, d); chk("glitch_status", d, exp_status());
        end

        // ---- Mode press latency, then W1C ----
        nMode = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            bus_read(32'h00, d);
            if (d[0] && lat < 0) lat = i;
        end
        chk("mode_latency_in_window", {31'd0, (lat >= 2 + (DB - 1) * TD) && (lat <= 2 + DB * TD + TD + 2)}, 32'd1);
        chk("mode_low_level", {31'd0, d[4]}, 32'd0);
        nMode = 1'b1;
        hold(24);
        exp_sticky[0] = 1'b1;
        bus_read(32'h00, d); chk("mode_sticky", d, exp_status());
        bus_write(32'h00, 32'h1);
        exp_sticky[0] = 1'b0;
        bus_read(32'h00, d); chk("mode_w1c", d, exp_status());

        // ---- randomised presses and clears ----
        for (int i = 0; i < 20; i++) begin
            idx = int'($urandom_range(0, 3));
            press(idx, int'($urandom_range(20, 40)));
            bus_read(32'h00, d); chk("rand_status", d, exp_status());
            if ($urandom_range(0, 1) == 1) begin
                m = 4'($urandom_range(0, 15));
                bus_write(32'h00, {28'd0, m});
                exp_sticky = exp_sticky & ~m;
                bus_read(32'h00, d); chk("rand_w1c", d, exp_status());
            end
        end
        bus_read(32'h0C, d); chk("rand_wcount", d, exp_wcnt);

        // IDLE transfer with HSEL high must not write
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h0C;
        step();
        HWDATA = 32'd0;
        bus_idle();
        step();
        bus_read(32'h0C, d); chk("idle_no_write", d, exp_wcnt);

        // ---- wheel period and count ----
        bus_write(32'h0C, 32'h1234);
        exp_wcnt = 32'd0;
        bus_write(32'h00, 32'hF);
        exp_sticky = 4'b0000;
        bus_read(32'h0C, d); chk("wcount_clear", d, 32'd0);
        s1 = int'($urandom_range(20, 200));
        t = cyc + 2;
        wait_until(t);                    Fork = 1'b1;
        wait_until(t + 10 * TD);          Fork = 1'b0;
        wait_until(t + s1 * TD);          Fork = 1'b1;
        wait_until(t + (s1 + 10) * TD);   Fork = 1'b0;
        wait_until(t + (s1 + 15) * TD);
        bus_read(32'h04, d); chk("wperiod_rand", d, 32'(s1));
        wait_until(t + (s1 + 100) * TD);  Fork = 1'b1;
        wait_until(t + (s1 + 110) * TD);  Fork = 1'b0;
        hold(24);
        exp_wcnt = 32'd3;
        exp_sticky[2] = 1'b1;
        bus_read(32'h04, d); chk("wperiod_100", d, 32'd100);
        bus_read(32'h0C, d); chk("wcount_3", d, exp_wcnt);
        bus_read(32'h00, d); chk("wheel_status", d, exp_status());

        // ---- crank period saturation ----
        t = cyc + 2;
        wait_until(t);                    Crank = 1'b1;
        wait_until(t + 10 * TD);          Crank = 1'b0;
        wait_until(t + 270 * TD);
        bus_read(32'h08, d); chk("cperiod_stopped", d, 32'hFF);
        wait_until(t + 300 * TD);         Crank = 1'b1;
        wait_until(t + 310 * TD);         Crank = 1'b0;
        wait_until(t + 320 * TD);
        bus_read(32'h08, d); chk("cperiod_after_stop", d, 32'hFF);
        wait_until(t + 350 * TD);         Crank = 1'b1;
        wait_until(t + 360 * TD);         Crank = 1'b0;
        wait_until(t + 370 * TD);
        bus_read(32'h08, d); chk("cperiod_50", d, 32'd50);
        exp_sticky[3] = 1'b1;
        bus_read(32'h00, d); chk("crank_status", d, exp_status());
        bus_read(32'h0C, d); chk("crank_no_wcount", d, exp_wcnt);

        // ---- event coincident with clears: locate event cycle by reading ----
        kfirst = -1;
        for (int k = 1; k <= 30; k++) begin
            if (kfirst < 0) begin
                coin_trial(0, k, r1, r2);
                if (r1 == 32'd1) kfirst = k;
            end
        end
        chk("coin_event_found", {31'd0, (kfirst > 1)}, 32'd1);
        if (kfirst > 1) begin
            kc = kfirst - 1;
            coin_trial(1, kc, r1, r2);
            chk("coin_clr_wcount", r1, 32'd1);
            chk("coin_clr_wheelp", {31'd0, r2[2]}, 32'd1);
            coin_trial(1, kc + 1, r1, r2);
            chk("late_clr_wcount", r1, 32'd0);
            coin_trial(2, kc, r1, r2);
            chk("coin_w1c_wheelp", {31'd0, r2[2]}, 32'd1);
            chk("coin_w1c_wcount", r1, 32'd1);
            coin_trial(2, kc + 1, r1, r2);
            chk("late_w1c_wheelp", {31'd0, r2[2]}, 32'd0);
        end

`ifdef SENSOR_IRQ_EN
        // ---- interrupt ----
        do_reset();
        bus_write(32'h10, 32'h2);
        bus_read(32'h10, d); chk("irq_mask_rd", d, 32'h2);
        chk("irq_idle", {31'd0, IRQ}, 32'd0);
        press(1, 25);
        chk("irq_trip", {31'd0, IRQ}, 32'd1);
        bus_addr(32'h00, 1'b1);
        step();
        HWDATA = 32'h2;
        bus_idle();
        step();
        chk("irq_clear_lag", {31'd0, IRQ}, 32'd1);
        step();
        chk("irq_cleared", {31'd0, IRQ}, 32'd0);
        exp_sticky[1] = 1'b0;
        press(0, 25);
        chk("irq_mode_masked", {31'd0, IRQ}, 32'd0);
        bus_read(32'h00, d); chk("irq_status", d, exp_status());
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
